// File: rtl/biquad8_coeff_loader.sv
// Coefficient bank and load sequencer for the biquad8 B-cascade DSP chain.
// The bank is shifted highest index first, then a single update strobe is issued.
module biquad8_coeff_loader #(
  parameter int NCOEFF   = 12,
  parameter int CWIDTH   = 18,
  parameter int ADDRBITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRBITS-1:0] cfg_addr_i,
  input  logic [CWIDTH-1:0]   cfg_dat_i,
  input  logic                cfg_wr_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_err_o,
  output logic [CWIDTH-1:0]   coeff_dat_o,
  output logic                coeff_wr_o,
  output logic                coeff_update_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESENT = 3'd1,
    HOLD    = 3'd2,
    UPDATE  = 3'd3,
    FIN     = 3'd4
  } state_t;

  localparam logic [ADDRBITS-1:0] LAST_IDX = ADDRBITS'(NCOEFF - 1);

  state_t              state;
  logic [ADDRBITS-1:0] idx;
  logic [CWIDTH-1:0]   bank [NCOEFF] = '{default: '0};

  logic                addr_ok;
  logic                wr_ok;
  logic                wr_bad;
  logic                start_ok;
  logic [CWIDTH-1:0]   first_word;

  // Write legality, start acceptance and same-cycle write forwarding for the first word
  always_comb begin
    addr_ok  = (32'(cfg_addr_i) < 32'(NCOEFF));
    wr_ok    = cfg_wr_i && (state == IDLE) && addr_ok;
    wr_bad   = cfg_wr_i && !wr_ok;
    start_ok = start_i && (state == IDLE);
    if (wr_ok && (cfg_addr_i == LAST_IDX)) begin
      first_word = cfg_dat_i;
    end else begin
      first_word = bank[LAST_IDX];
    end
  end

  // Coefficient bank storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      bank[cfg_addr_i] <= cfg_dat_i;
    end
  end

  // Load sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      cfg_err_o      <= 1'b0;
      coeff_dat_o    <= '0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
    end else begin
      if (wr_bad) begin
        cfg_err_o <= 1'b1;
      end else if (start_ok) begin
        cfg_err_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state       <= PRESENT;
            idx         <= LAST_IDX;
            coeff_dat_o <= first_word;
            coeff_wr_o  <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        PRESENT: begin
          coeff_wr_o <= 1'b0;
          state      <= HOLD;
        end
        HOLD: begin
          if (idx == '0) begin
            coeff_update_o <= 1'b1;
            state          <= UPDATE;
          end else begin
            // Bank is frozen while busy, so reading the next entry here is safe
            idx         <= idx - 1'b1;
            coeff_dat_o <= bank[idx - 1'b1];
            coeff_wr_o  <= 1'b1;
            state       <= PRESENT;
          end
        end
        UPDATE: begin
          coeff_update_o <= 1'b0;
          done_o         <= 1'b1;
          busy_o         <= 1'b0;
          state          <= FIN;
        end
        FIN: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state          <= IDLE;
          busy_o         <= 1'b0;
          done_o         <= 1'b0;
          coeff_wr_o     <= 1'b0;
          coeff_update_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/biquad8_coeff_loader.md
Name: biquad8_coeff_loader

Overview:
- Source end of the biquad coefficient load interface: drives `coeff_dat`, `coeff_wr` and `coeff_update` into the B-cascade DSP chain of the incremental IIR stage.
- Holds a local coefficient bank written by the register interface. On command it shifts the bank into the chain and then issues one update strobe.
- Sits between the register decoder and the biquad8 IIR blocks. One loader feeds one cascade chain.

Parameters:
- NCOEFF, 12, number of DSPs in the B cascade (2*(NSAMP-2) for NSAMP=8).
- CWIDTH, 18, coefficient width (DSP B port).
- ADDRBITS, 4, width of the bank address; must satisfy 2^ADDRBITS >= NCOEFF.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- cfg_addr_i  input  ADDRBITS  bank write address.
- cfg_dat_i  input  CWIDTH  bank write data.
- cfg_wr_i  input  1  bank write strobe.
- start_i  input  1  begin load sequence (single-cycle pulse or level).
- busy_o  output  1  load sequence in progress.
- done_o  output  1  one-cycle pulse at sequence completion.
- cfg_err_o  output  1  sticky: illegal bank write occurred.
- coeff_dat_o  output  CWIDTH  coefficient word to DSP chain.
- coeff_wr_o  output  1  shift strobe (CEB1 source).
- coeff_update_o  output  1  update strobe (CEB2 source).

Behaviour:
- Reset (async, active-high) forces:
  - all outputs to 0;
  - state IDLE, counter 0, cfg_err_o 0.
  - Bank contents are not reset. A bench reads them as 0 only if the initial value is set to 0, which is required.
- Bank: NCOEFF x CWIDTH registers.
  - cfg_wr_i in IDLE with cfg_addr_i < NCOEFF writes the entry on that clock edge.
  - cfg_addr_i >= NCOEFF: write dropped, cfg_err_o set.
  - cfg_wr_i while busy_o=1: write dropped, cfg_err_o set.
- cfg_err_o clears only on an accepted start or on rst.
- start_i is sampled only in IDLE. start_i while busy is ignored and has no effect on cfg_err_o.
- Same-cycle cfg_wr_i and start_i in IDLE: the write is accepted first, and the load uses the new value.
- States:
  - IDLE: on start_i, set idx=NCOEFF-1 and go to PRESENT.
  - PRESENT: coeff_dat_o=bank[idx], coeff_wr_o=1; go to HOLD.
  - HOLD: coeff_dat_o holds bank[idx], coeff_wr_o=0. If idx==0 go to UPDATE; else idx-=1 and go to PRESENT.
  - UPDATE: coeff_update_o=1 for exactly one cycle; go to FIN.
  - FIN: done_o=1 for one cycle; go to IDLE.
- Why each word is held for 2 cycles: the receiver re-registers coeff_wr before it drives CEB1. The word must therefore be stable in both the strobe cycle and the following cycle.
- Word order is highest index first, so after NCOEFF shifts bank[0] lands in the first DSP and bank[NCOEFF-1] in the last.
- Timing, with start sampled at edge 0:
  - busy_o is 1 from cycle 1 through the UPDATE cycle.
  - PRESENT cycles are 1, 3, …, 2*NCOEFF-1.
  - UPDATE is cycle 2*NCOEFF+1 (cycle 25 for the default).
  - done_o is cycle 2*NCOEFF+2.
  - busy_o is 0 in the FIN cycle.
- Exactly NCOEFF coeff_wr_o pulses and exactly one coeff_update_o pulse per sequence. coeff_wr_o and coeff_update_o are never high together.
- coeff_dat_o in IDLE/FIN holds the last driven word (0 after reset).
- rst mid-sequence:
  - aborts immediately; no update pulse is emitted.
  - The partially shifted chain is left as is. The DSP B2 registers keep their old active coefficients because no update occurred.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Write bank[i]=0x100+i for i=0..11, pulse start -> coeff_wr_o pulses in cycles 1,3,…,23 with data 0x10B,0x10A,…,0x100, each data held 2 cycles; coeff_update_o in cycle 25 only; done_o in cycle 26; busy_o high cycles 1–25.
- Write cfg_addr_i=12 (and 15) -> bank unchanged, cfg_err_o=1. Then start -> cfg_err_o cleared in cycle 1.
- During load, assert cfg_wr_i to addr 3 with 0x3FFFF and a second start_i -> write dropped, cfg_err_o=1, sequence length unchanged (still 12 wr pulses, one update). A following load shows bank[3] unchanged.
- Same-cycle cfg_wr_i(addr 11, 0x2AAAA) and start_i in IDLE -> first word driven in cycle 1 is 0x2AAAA.
- Assert rst asynchronously at cycle 10 of a load -> all outputs 0 before the next edge; no coeff_update_o ever; after release the module is IDLE and a new start produces a full correct sequence.
- Negative-valued coefficient 0x20000 at bank[0] -> last shifted word is 0x20000 bit-exact (no sign manipulation), held 2 cycles.
